// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the pipeline-control state type.
// Imported by pipe_ctrl and by anything that decodes icode/stat fields.
package y86_pkg;

  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] RRMOVQ = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  localparam logic [3:0] RNONE  = 4'hF;

  localparam logic [2:0] BUB = 3'd0;
  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] HLT = 3'd2;
  localparam logic [2:0] ADR = 3'd3;
  localparam logic [2:0] INS = 3'd4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_e;

  // A stage status that must stop the machine once it reaches writeback.
  function automatic logic isExc(input logic [2:0] stat);
    return (stat == HLT) || (stat == ADR) || (stat == INS);
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (en && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: hazard stall/bubble generation, CC-write gating,
// exception drain to a sticky halt, and saturating performance counters.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             set_cc,
  output logic             halted,
  output logic [2:0]       halt_stat,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  ctrl_state_e state_q, state_d;
  logic [2:0]  haltStat_q, haltStat_d;

  logic loadUse, misPred, retPending, mExc, wExc, counting;

  assign loadUse    = ((E_icode == MRMOVQ) || (E_icode == POPQ)) && (E_dstM != RNONE) &&
                      ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign misPred    = (E_icode == JXX) && !e_Cnd;
  assign retPending = (D_icode == RET) || (E_icode == RET) || (M_icode == RET);
  assign mExc       = isExc(m_stat);
  assign wExc       = isExc(W_stat);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      haltStat_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      haltStat_q <= haltStat_d;
    end
  end

  // A writeback exception wins over a memory one, so both together skip DRAIN.
  always_comb begin
    state_d    = state_q;
    haltStat_d = haltStat_q;
    case (state_q)
      RUN: begin
        if (wExc) begin
          state_d    = HALTED;
          haltStat_d = W_stat;
        end else if (mExc) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (wExc) begin
          state_d    = HALTED;
          haltStat_d = W_stat;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    W_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    set_cc   = 1'b0;
    if (reset) begin
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end else if (state_q == HALTED) begin
      F_stall = 1'b1;
      D_stall = 1'b1;
      W_stall = 1'b1;
    end else begin
      F_stall  = loadUse || retPending;
      D_stall  = loadUse;
      D_bubble = misPred || (retPending && !loadUse);
      E_bubble = misPred || loadUse;
      M_bubble = mExc || wExc;
      W_stall  = wExc;
      set_cc   = (E_icode == OPQ) && !mExc && !wExc;
    end
  end

  assign halted    = (state_q == HALTED);
  assign halt_stat = haltStat_q;
  assign counting  = !reset && (state_q != HALTED);

  sat_counter #(.CNT_W(CNT_W)) uCycCnt (
    .clk(clk), .reset(reset), .en(counting), .count(cyc_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) uRetireCnt (
    .clk(clk), .reset(reset), .en(counting && (W_stat == AOK)), .count(retire_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) uLuCnt (
    .clk(clk), .reset(reset), .en(counting && loadUse), .count(lu_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) uMpCnt (
    .clk(clk), .reset(reset), .en(counting && misPred), .count(mp_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) uRetCnt (
    .clk(clk), .reset(reset), .en(counting && retPending && !loadUse), .count(ret_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; a second 4-bit-counter copy shares the
// same stimulus so counter saturation can be observed.
module tb_pipe_ctrl;
  import y86_pkg::*;

  logic clk;
  logic reset;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic e_Cnd;
  logic [2:0] m_stat, W_stat;

  logic F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc, halted;
  logic [2:0] halt_stat;
  logic [31:0] cyc_cnt, retire_cnt, lu_cnt, mp_cnt, ret_cnt;

  logic satFStall, satDStall, satWStall, satDBubble, satEBubble, satMBubble, satSetCc, satHalted;
  logic [2:0] satHaltStat;
  logic [3:0] satCyc, satRetire, satLu, satMp, satRet;

  logic [6:0] ctrl;
  assign ctrl = {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc};

  int checks;
  int failures;
  int expCyc, expRetire, expLu, expMp, expRet;
  bit expHalted;

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
    .set_cc(set_cc), .halted(halted), .halt_stat(halt_stat),
    .cyc_cnt(cyc_cnt), .retire_cnt(retire_cnt), .lu_cnt(lu_cnt),
    .mp_cnt(mp_cnt), .ret_cnt(ret_cnt)
  );

  pipe_ctrl #(.CNT_W(4)) dutSat (
    .clk(clk), .reset(reset), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(satFStall), .D_stall(satDStall), .W_stall(satWStall),
    .D_bubble(satDBubble), .E_bubble(satEBubble), .M_bubble(satMBubble),
    .set_cc(satSetCc), .halted(satHalted), .halt_stat(satHaltStat),
    .cyc_cnt(satCyc), .retire_cnt(satRetire), .lu_cnt(satLu),
    .mp_cnt(satMp), .ret_cnt(satRet)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] dIcode, input logic [3:0] srcA, input logic [3:0] srcB,
                               input logic [3:0] eIcode, input logic [3:0] eDstM, input logic cnd,
                               input logic [3:0] mIcode, input logic [2:0] mStat, input logic [2:0] wStat);
    D_icode = dIcode;
    d_srcA  = srcA;
    d_srcB  = srcB;
    E_icode = eIcode;
    E_dstM  = eDstM;
    e_Cnd   = cnd;
    M_icode = mIcode;
    m_stat  = mStat;
    W_stat  = wStat;
    #1;
  endtask

  task automatic applyIdle();
    applyStimulus(NOP, RNONE, RNONE, NOP, RNONE, 1'b0, NOP, AOK, AOK);
  endtask

  // Advance one edge and update the expected counters for the events the vector is meant to raise.
  task automatic clockEdge(input bit lu, input bit mp, input bit rt);
    bit wasReset;
    bit retiring;
    wasReset = reset;
    retiring = (W_stat == AOK);
    @(posedge clk);
    #1;
    if (wasReset) begin
      expCyc = 0; expRetire = 0; expLu = 0; expMp = 0; expRet = 0;
      expHalted = 1'b0;
    end else if (!expHalted) begin
      expCyc++;
      if (retiring) expRetire++;
      if (lu) expLu++;
      if (mp) expMp++;
      if (rt) expRet++;
    end
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, ".cyc"},    cyc_cnt,    32'(expCyc));
    checkOutput({tag, ".retire"}, retire_cnt, 32'(expRetire));
    checkOutput({tag, ".lu"},     lu_cnt,     32'(expLu));
    checkOutput({tag, ".mp"},     mp_cnt,     32'(expMp));
    checkOutput({tag, ".ret"},    ret_cnt,    32'(expRet));
    checkOutput({tag, ".satCyc"}, 32'(satCyc), 32'((expCyc > 15) ? 15 : expCyc));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    expHalted = 1'b0;
    expCyc = 0; expRetire = 0; expLu = 0; expMp = 0; expRet = 0;

    reset = 1'b1;
    applyIdle();
    checkOutput("resetCtrl", 32'(ctrl), 32'(7'b0001110));
    clockEdge(0, 0, 0);
    checkOutput("resetHalted", 32'(halted), 32'(0));
    checkOutput("resetHaltStat", 32'(halt_stat), 32'(0));
    checkCounters("reset");

    reset = 1'b0;
    applyIdle();
    checkOutput("idleCtrl", 32'(ctrl), 32'(7'b0000000));
    clockEdge(0, 0, 0);
    checkOutput("firstCyc", cyc_cnt, 32'd1);

    applyStimulus(NOP, 4'd3, RNONE, MRMOVQ, 4'd3, 1'b0, NOP, AOK, AOK);
    checkOutput("loadUseA", 32'(ctrl), 32'(7'b1100100));
    clockEdge(1, 0, 0);

    applyStimulus(NOP, RNONE, RNONE, MRMOVQ, RNONE, 1'b0, NOP, AOK, AOK);
    checkOutput("loadUseRnone", 32'(ctrl), 32'(7'b0000000));
    clockEdge(0, 0, 0);

    applyStimulus(NOP, 4'd1, 4'd5, POPQ, 4'd5, 1'b0, NOP, AOK, AOK);
    checkOutput("loadUsePopB", 32'(ctrl), 32'(7'b1100100));
    clockEdge(1, 0, 0);

    applyStimulus(NOP, RNONE, RNONE, JXX, RNONE, 1'b0, NOP, AOK, AOK);
    checkOutput("mispred", 32'(ctrl), 32'(7'b0001100));
    clockEdge(0, 1, 0);

    applyStimulus(NOP, RNONE, RNONE, JXX, RNONE, 1'b1, NOP, AOK, AOK);
    checkOutput("jxxTaken", 32'(ctrl), 32'(7'b0000000));
    clockEdge(0, 0, 0);

    applyStimulus(NOP, RNONE, RNONE, OPQ, RNONE, 1'b0, NOP, AOK, AOK);
    checkOutput("opqSetCc", 32'(ctrl), 32'(7'b0000001));
    clockEdge(0, 0, 0);
    checkCounters("afterHazards");

    applyStimulus(RET, RNONE, RNONE, NOP, RNONE, 1'b0, NOP, AOK, AOK);
    checkOutput("retInD", 32'(ctrl), 32'(7'b1001000));
    clockEdge(0, 0, 1);
    applyStimulus(NOP, RNONE, RNONE, RET, RNONE, 1'b0, NOP, AOK, AOK);
    checkOutput("retInE", 32'(ctrl), 32'(7'b1001000));
    clockEdge(0, 0, 1);
    applyStimulus(NOP, RNONE, RNONE, NOP, RNONE, 1'b0, RET, AOK, AOK);
    checkOutput("retInM", 32'(ctrl), 32'(7'b1001000));
    clockEdge(0, 0, 1);
    checkOutput("retCnt3", ret_cnt, 32'd3);

    applyStimulus(RET, 4'd3, RNONE, MRMOVQ, 4'd3, 1'b0, NOP, AOK, AOK);
    checkOutput("retPlusLoadUse", 32'(ctrl), 32'(7'b1100100));
    clockEdge(1, 0, 0);

    applyStimulus(RET, RNONE, RNONE, JXX, RNONE, 1'b0, NOP, AOK, AOK);
    checkOutput("retPlusMispred", 32'(ctrl), 32'(7'b1001100));
    clockEdge(0, 1, 1);
    checkCounters("afterRet");

    applyStimulus(NOP, RNONE, RNONE, OPQ, RNONE, 1'b0, NOP, ADR, AOK);
    checkOutput("opqMemExc", 32'(ctrl), 32'(7'b0000010));
    clockEdge(0, 0, 0);
    checkOutput("drainNotHalted", 32'(halted), 32'(0));

    applyStimulus(NOP, 4'd2, RNONE, MRMOVQ, 4'd2, 1'b0, NOP, AOK, AOK);
    checkOutput("drainLoadUse", 32'(ctrl), 32'(7'b1100100));
    clockEdge(1, 0, 0);
    applyStimulus(NOP, RNONE, RNONE, OPQ, RNONE, 1'b0, NOP, AOK, AOK);
    checkOutput("drainSetCc", 32'(ctrl), 32'(7'b0000001));
    clockEdge(0, 0, 0);
    checkCounters("drain");

    applyStimulus(NOP, RNONE, RNONE, NOP, RNONE, 1'b0, NOP, AOK, HLT);
    checkOutput("haltCycleCtrl", 32'(ctrl), 32'(7'b0010010));
    checkOutput("haltCycleNotYet", 32'(halted), 32'(0));
    clockEdge(0, 0, 0);
    expHalted = 1'b1;
    checkOutput("haltedSet", 32'(halted), 32'(1));
    checkOutput("haltStatHlt", 32'(halt_stat), 32'(HLT));

    for (int i = 0; i < 10; i++) begin
      applyStimulus(RET, 4'd3, RNONE, MRMOVQ, 4'd3, 1'b0, NOP, ADR, ADR);
      checkOutput("haltedCtrl", 32'(ctrl), 32'(7'b1110000));
      clockEdge(1, 0, 0);
    end
    checkOutput("haltStatHeld", 32'(halt_stat), 32'(HLT));
    checkCounters("frozen");

    reset = 1'b1;
    applyIdle();
    checkOutput("resetFromHaltCtrl", 32'(ctrl), 32'(7'b0001110));
    clockEdge(0, 0, 0);
    checkOutput("resetClearsHalted", 32'(halted), 32'(0));
    checkOutput("resetClearsStat", 32'(halt_stat), 32'(0));
    checkCounters("resetFromHalt");
    reset = 1'b0;
    applyIdle();
    clockEdge(0, 0, 0);
    checkOutput("cycAfterRelease", cyc_cnt, 32'd1);

    applyStimulus(NOP, RNONE, RNONE, NOP, RNONE, 1'b0, NOP, ADR, INS);
    checkOutput("bothExcCtrl", 32'(ctrl), 32'(7'b0010010));
    clockEdge(0, 0, 0);
    expHalted = 1'b1;
    checkOutput("directHalt", 32'(halted), 32'(1));
    checkOutput("directHaltStat", 32'(halt_stat), 32'(INS));

    reset = 1'b1;
    applyIdle();
    clockEdge(0, 0, 0);
    reset = 1'b0;
    applyIdle();
    for (int i = 0; i < 20; i++) begin
      clockEdge(0, 0, 0);
    end
    checkOutput("satCyc15", 32'(satCyc), 32'd15);
    checkOutput("satRetire15", 32'(satRetire), 32'd15);
    checkCounters("saturate");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
